// File: rtl/eqa_coeff_loader_pkg.sv
// Shared equalizer definitions: coefficient geometry, loader state encoding
// and the preset-memory address packing used by the coefficient loader.
package eqa_coeff_loader_pkg;

  localparam int COEFFICIENT_DATA_WIDTH = 18;
  localparam int NUM_BANDS              = 5;
  localparam int COEFF_PAIRS            = 3;
  localparam int PRESET_W               = 3;
  localparam int BAND_W                 = 3;
  localparam int PAIR_W                 = 2;
  localparam int ADDR_W                 = BAND_W + PRESET_W + PAIR_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_READ      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_SET       = 3'd5,
    ST_DONE      = 3'd6
  } loader_state_t;

  // Preset memory layout: one contiguous block of pairs per {band, preset}.
  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [BAND_W-1:0]   band,
    input logic [PRESET_W-1:0] preset,
    input logic [PAIR_W-1:0]   pair_idx
  );
    return {band, preset, pair_idx};
  endfunction

endpackage

// File: rtl/eqa_coeff_loader.sv
// Coefficient loader: fetches a band's a/b pairs from the preset memory,
// writes them to the addressed band filter and then commits the set.
module eqa_coeff_loader
  import eqa_coeff_loader_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     upd_req,
  input  logic [BAND_W-1:0]                        upd_band,
  input  logic [PRESET_W-1:0]                      upd_preset,
  output logic                                     upd_ack,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  input  logic                                     eq_idle,
  output logic                                     mem_rd,
  output logic [ADDR_W-1:0]                        mem_addr,
  input  logic signed [COEFFICIENT_DATA_WIDTH-1:0] mem_a,
  input  logic signed [COEFFICIENT_DATA_WIDTH-1:0] mem_b,
  output logic signed [COEFFICIENT_DATA_WIDTH-1:0] coeff_a,
  output logic signed [COEFFICIENT_DATA_WIDTH-1:0] coeff_b,
  output logic [NUM_BANDS-1:0]                     coeff_we,
  output logic [NUM_BANDS-1:0]                     coeff_set
);

  loader_state_t                            state;
  logic [BAND_W-1:0]                        band;
  logic [PRESET_W-1:0]                      preset;
  logic [PAIR_W-1:0]                        pair_idx;
  logic signed [COEFFICIENT_DATA_WIDTH-1:0] hold_a;
  logic signed [COEFFICIENT_DATA_WIDTH-1:0] hold_b;
  logic                                     band_bad;
  logic [NUM_BANDS-1:0]                     band_onehot;
  logic                                     writing;

  assign band_bad    = (band >= BAND_W'(NUM_BANDS));
  assign band_onehot = band_bad ? '0 : (NUM_BANDS'(1) << band);
  assign writing     = |coeff_we;

  // Memory data arrives in the same cycle as the write strobe, so the bus
  // forwards it live during the strobe and the hold register keeps it after.
  assign coeff_a = writing ? mem_a : hold_a;
  assign coeff_b = writing ? mem_b : hold_b;

  // Load sequencer; every strobe is a registered one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      band      <= '0;
      preset    <= '0;
      pair_idx  <= '0;
      upd_ack   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      coeff_we  <= '0;
      coeff_set <= '0;
    end else begin
      upd_ack   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      coeff_we  <= '0;
      coeff_set <= '0;
      case (state)
        ST_IDLE: begin
          // busy is still high during the done/err cycle; a held request
          // waits one more cycle so acceptance follows the busy fall.
          busy <= 1'b0;
          if (upd_req && !busy) begin
            band     <= upd_band;
            preset   <= upd_preset;
            pair_idx <= '0;
            upd_ack  <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          busy <= 1'b1;
          if (band_bad) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          // Only gate on the equalizer once, before the first pair.
          if (eq_idle) state <= ST_READ;
        end
        ST_READ: begin
          mem_rd   <= 1'b1;
          mem_addr <= pack_addr(band, preset, pair_idx);
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          coeff_we <= band_onehot;
          if (pair_idx == PAIR_W'(COEFF_PAIRS - 1)) begin
            state <= ST_SET;
          end else begin
            pair_idx <= pair_idx + PAIR_W'(1);
            state    <= ST_READ;
          end
        end
        ST_SET: begin
          coeff_set <= band_onehot;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Keep the last written pair on the shared bus between loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (writing) begin
      hold_a <= mem_a;
      hold_b <= mem_b;
    end
  end

endmodule

// File: doc/eqa_coeff_loader.md
# eqa_coeff_loader

Sequencer that loads IIR coefficient sets from a preset coefficient memory into the five equalizer band filters. It accepts one band-update request at a time from the control side and fetches the band's coefficient pairs from a synchronous-read memory. It writes each pair to the target filter with a one-hot write strobe, then commits the set with a one-hot set strobe. It sits between the host/UI control logic and the coefficient ports of the 5-band equalizer.

## Interface
- COEFFICIENT_DATA_WIDTH, 18, width of each a/b coefficient
- NUM_BANDS, 5, number of filter bands (one-hot strobe width)
- COEFF_PAIRS, 3, a/b pairs written per band load (1..4)
- PRESET_W, 3, preset index width
- ADDR_W, 3+PRESET_W+2, memory address width = {band[2:0], preset, pair_idx[1:0]}

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- upd_req  in  1  band-update request; held by requester until upd_ack
- upd_band  in  3  target band, 0..NUM_BANDS-1
- upd_preset  in  PRESET_W  preset to load
- upd_ack  out  1  one-cycle pulse: request accepted, band/preset captured
- busy  out  1  high from acceptance until done/err cycle inclusive
- done  out  1  one-cycle pulse after coeff_set issued
- err  out  1  one-cycle pulse: band out of range, nothing written
- eq_idle  in  1  equalizer idle (all filters input_ready, no sample in flight)
- mem_rd  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_a, mem_b  in  COEFFICIENT_DATA_WIDTH  read data, valid one cycle after mem_rd
- coeff_a, coeff_b  out  COEFFICIENT_DATA_WIDTH  shared coefficient bus to all bands
- coeff_we  out  NUM_BANDS  one-hot write strobe
- coeff_set  out  NUM_BANDS  one-hot commit strobe

## Operation
- States: IDLE, CHECK, WAIT_IDLE, READ, WRITE, SET, DONE.
- IDLE: if upd_req, capture band/preset, pulse upd_ack, pair_idx<=0, go CHECK.
- CHECK: band >= NUM_BANDS -> pulse err, go IDLE; else go WAIT_IDLE.
- WAIT_IDLE: stay until eq_idle=1, then go READ. eq_idle is only sampled here; deassertion later does not stall or abort.
- READ: mem_rd=1, mem_addr={band,preset,pair_idx}; go WRITE.
- WRITE: coeff_a<=mem_a, coeff_b<=mem_b, coeff_we[band]=1 for one cycle.
  - If pair_idx==COEFF_PAIRS-1, go SET.
  - Else pair_idx++, go READ.
- SET: coeff_set[band]=1 for one cycle; go DONE.
- DONE: pulse done; go IDLE.
- upd_req while busy: ignored, no ack. The requester keeps it held and it is accepted on the next IDLE cycle.
- coeff_a/coeff_b hold the last written value between loads. They are valid in the same cycle as coeff_we.
- Outputs are registered; at most one bit of coeff_we|coeff_set is high in any cycle.

## Timing
- Reset values: all outputs 0, state IDLE, captured band/preset 0.
- Reset mid-load: everything returns to reset values immediately. No coeff_set is issued, so any partially written pairs remain uncommitted in the filter.
- Accept: upd_ack in cycle T; busy rises at T+1.
- With eq_idle already high, cycle offsets from T:
  - READ at T+3
  - first coeff_we at T+4
  - each further pair 2 cycles later
  - coeff_set at T+3+2*COEFF_PAIRS
  - done one cycle after coeff_set
  - With COEFF_PAIRS=3: coeff_set at T+9, done at T+10.
- busy drops the cycle after done/err. The earliest next upd_ack is the cycle after busy drops.
- Error path: err at T+1, no mem_rd, no strobes.

## Structure
- Shared equalizer package holds:
  - COEFFICIENT_DATA_WIDTH, NUM_BANDS, COEFF_PAIRS
  - the loader state enum
  - the address-packing function {band, preset, pair_idx}
- Single module; no sub-module needed. Strobe generation is a one-hot decode of the captured band inside the module.

## Test plan
- Reset then idle: all outputs 0; no activity with upd_req=0 for 20 cycles.
- Band 2, preset 5, eq_idle=1, memory returns a=addr+1, b=addr+2:
  - coeff_we=5'b00100 three times at T+4, T+6, T+8, with correct a/b for addresses {2,5,0..2}
  - coeff_set=5'b00100 at T+9, done at T+10
- eq_idle=0 for 7 cycles after ack: no mem_rd until eq_idle rises; then the normal sequence follows. Dropping eq_idle mid-load does not stall.
- upd_band=6: err at T+1, no mem_rd, no coeff_we/coeff_set, busy low again at T+2.
- Back-to-back: second upd_req held during a load is acked only after busy falls, then a full second sequence to a different band follows.
- Reset asserted between the second and third coeff_we: all outputs 0 the same cycle, no coeff_set ever issued, next request starts cleanly.
